// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle.
// Column drive, raw rows and the accepted-key outputs.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keypad_value;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output keypad_value,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  keypad_value,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with sweep-based debounce.
// One column driven low at a time; one FSM step per sweep.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            reset,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {
    IDLE,
    CANDIDATE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB        = 4'(DEBOUNCE_SCANS);

  logic [3:0]  row_s1;
  logic [3:0]  row_s2;
  logic [15:0] dwell;
  logic [1:0]  col;
  logic        last;
  logic        eval;

  logic        hit;
  logic [1:0]  hit_row;
  logic        acc_found;
  logic [3:0]  acc_code;
  logic        sw_found;
  logic [3:0]  sw_code;

  state_t      state;
  state_t      state_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic [3:0]  cand;
  logic [3:0]  cand_n;
  logic [3:0]  value;
  logic [3:0]  value_n;
  logic        valid;
  logic        valid_n;
  logic        held;
  logic        held_n;

  assign last = (dwell == DWELL_LAST);
  assign eval = last && (col == 2'd3);

  assign kp.col_out      = ~(4'b0001 << col);
  assign kp.keypad_value = value;
  assign kp.key_valid    = valid;
  assign kp.key_held     = held;

  // Two-flop synchronizer for the asynchronous rows (idle high).
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= kp.row_in;
      row_s2 <= row_s1;
    end
  end

  // Dwell counter and column index; column advances on dwell wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell <= '0;
      col   <= 2'd0;
    end else if (last) begin
      dwell <= '0;
      col   <= col + 2'd1;
    end else begin
      dwell <= dwell + 16'd1;
    end
  end

  // Lowest low row in the synchronized sample.
  always_comb begin
    hit     = (row_s2 != 4'hF);
    hit_row = 2'd0;
    priority case (1'b1)
      !row_s2[0]: hit_row = 2'd0;
      !row_s2[1]: hit_row = 2'd1;
      !row_s2[2]: hit_row = 2'd2;
      !row_s2[3]: hit_row = 2'd3;
      default:    hit_row = 2'd0;
    endcase
  end

  // Sweep result: earlier columns win, column 3 sample merged in.
  always_comb begin
    sw_found = acc_found | hit;
    sw_code  = acc_found ? acc_code : {hit_row, col};
  end

  // Holds the first key seen in columns 0..2 of the current sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_found <= 1'b0;
      acc_code  <= 4'h0;
    end else if (eval) begin
      acc_found <= 1'b0;
      acc_code  <= 4'h0;
    end else if (last && !acc_found && hit) begin
      acc_found <= 1'b1;
      acc_code  <= {hit_row, col};
    end
  end

  // Debounce FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'h0;
      cand  <= 4'h0;
      value <= 4'h0;
      valid <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
      value <= value_n;
      valid <= valid_n;
      held  <= held_n;
    end
  end

  // Debounce next-state: one step per sweep on the column-3 sample.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    value_n = value;
    valid_n = 1'b0;
    held_n  = held;
    if (eval) begin
      unique case (state)
        IDLE: begin
          if (sw_found) begin
            state_n = CANDIDATE;
            cand_n  = sw_code;
            cnt_n   = 4'd1;
            if (cnt_n == DEB) begin
              state_n = PRESSED;
              value_n = cand_n;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end
          end
        end
        CANDIDATE: begin
          if (!sw_found) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end else begin
            if (sw_code == cand) begin
              cnt_n = cnt + 4'd1;
            end else begin
              cand_n = sw_code;
              cnt_n  = 4'd1;
            end
            if (cnt_n == DEB) begin
              state_n = PRESSED;
              value_n = cand_n;
              valid_n = 1'b1;
              held_n  = 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!sw_found) begin
            state_n = RELEASE;
            cnt_n   = 4'd1;
            if (cnt_n == DEB) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
              held_n  = 1'b0;
            end
          end
        end
        RELEASE: begin
          if (sw_found) begin
            state_n = PRESSED;
            cnt_n   = 4'd0;
          end else begin
            cnt_n = cnt + 4'd1;
            if (cnt_n == DEB) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
              held_n  = 1'b0;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner.
// Stimulus queues expected pulses; a monitor pops on key_valid.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int SWEEP = 16;

  localparam int K_R2C1 = 9;
  localparam int K_R0C2 = 2;
  localparam int K_R1C3 = 7;
  localparam int K_R3C0 = 12;
  localparam int K_R0C0 = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pressed = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];
  logic prev_valid = 1'b0;

  keypad_scanner_if kp();

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp.master)
  );

  always #5 clk = ~clk;

  // Keypad model: row r pulled low when a pressed key sits on a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kp.row_in[r] = ~|(pressed[r*4 +: 4] & ~kp.col_out);
    end
  end

  // Monitor: every key_valid pulse must match the next queued value.
  always @(negedge clk) begin
    logic [3:0] e;
    if (kp.key_valid) begin
      vectors++;
      if (prev_valid) begin
        miscompares++;
        $display("FAIL valid_twice: key_valid high two cycles running");
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got value %h, required no pulse",
                 kp.keypad_value);
      end else begin
        e = exp_q.pop_front();
        if (kp.keypad_value !== e) begin
          miscompares++;
          $display("FAIL pulse_value: got %h, required %h",
                   kp.keypad_value, e);
        end
      end
    end
    prev_valid = kp.key_valid;
  end

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sweeps(input int n);
    repeat (n * SWEEP) @(posedge clk);
    #1;
  endtask

  task automatic key(input int k);
    pressed = '0;
    pressed[k] = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_col"}, kp.col_out, 4'b1110);
    check({tag, "_value"}, kp.keypad_value, 4'h0);
    check({tag, "_valid"}, {3'b0, kp.key_valid}, 4'h0);
    check({tag, "_held"}, {3'b0, kp.key_held}, 4'h0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outs("reset");
    repeat (SD) @(posedge clk);
    #1 check("col1", kp.col_out, 4'b1101);
    repeat (SD) @(posedge clk);
    #1 check("col2", kp.col_out, 4'b1011);
    repeat (SD) @(posedge clk);
    #1 check("col3", kp.col_out, 4'b0111);
    repeat (SD) @(posedge clk);
    #1 check("col_wrap", kp.col_out, 4'b1110);

    // Row 2 / column 1 held for five sweeps: one pulse, code 9.
    key(K_R2C1);
    exp_q.push_back(4'h9);
    sweeps(5);
    check("press_value", kp.keypad_value, 4'h9);
    check("press_held", {3'b0, kp.key_held}, 4'h1);

    // One-sweep release is a glitch: no new pulse.
    pressed = '0;
    sweeps(1);
    key(K_R2C1);
    sweeps(1);
    check("short_rel_held", {3'b0, kp.key_held}, 4'h1);

    // Two-sweep release is accepted, then a fresh press.
    pressed = '0;
    sweeps(2);
    check("release_held", {3'b0, kp.key_held}, 4'h0);
    check("release_value", kp.keypad_value, 4'h9);
    key(K_R2C1);
    exp_q.push_back(4'h9);
    sweeps(2);
    check("repress_held", {3'b0, kp.key_held}, 4'h1);

    // Bounce on alternate sweeps never qualifies.
    pressed = '0;
    sweeps(2);
    for (int i = 0; i < 3; i++) begin
      key(K_R0C2);
      sweeps(1);
      pressed = '0;
      sweeps(1);
    end
    check("bounce_value", kp.keypad_value, 4'h9);
    check("bounce_held", {3'b0, kp.key_held}, 4'h0);

    // Two keys: lowest column wins -> row3/col0.
    pressed = '0;
    pressed[K_R1C3] = 1'b1;
    pressed[K_R3C0] = 1'b1;
    exp_q.push_back(4'hC);
    sweeps(2);
    check("multi_value", kp.keypad_value, 4'hC);
    check("multi_held", {3'b0, kp.key_held}, 4'h1);

    // Switching keys while pressed is ignored.
    key(K_R0C0);
    sweeps(3);
    check("switch_value", kp.keypad_value, 4'hC);
    check("switch_held", {3'b0, kp.key_held}, 4'h1);

    // Press 9, then reset mid-press.
    pressed = '0;
    sweeps(2);
    key(K_R2C1);
    exp_q.push_back(4'h9);
    sweeps(2);
    check("pre_rst_held", {3'b0, kp.key_held}, 4'h1);
    sweeps(1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outs("midrst");
    exp_q.push_back(4'h9);
    sweeps(2);
    check("post_rst_value", kp.keypad_value, 4'h9);
    check("post_rst_held", {3'b0, kp.key_held}, 4'h1);

    pressed = '0;
    sweeps(1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_pulses: got %0d unconsumed, required 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each column is driven, legal range 4..65535.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive agreeing full sweeps needed to accept a press or a release, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port row_in, input, 4: raw keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port col_out, output, 4: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port keypad_value, output, 4: last accepted key code, held constant until the next accepted press; feeds the song-select input of music_player.
REQ-008 SHALL have port key_valid, output, 1: one-cycle pulse when a new press is accepted.
REQ-009 SHALL have port key_held, output, 1: high from press acceptance until release acceptance.

Function
REQ-010 SHALL pass row_in through a two-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 SHALL drive column c as col_out = ~(4'b0001 << c), with c stepping 0,1,2,3,0,... and each column held for exactly SCAN_DIV cycles.
REQ-012 SHALL sample synchronized rows only on the last cycle of each column dwell.
REQ-013 SHALL define one sweep as columns 0..3; sweep result = first low row found, scanning lowest column first and lowest row first within a column; otherwise "none".
REQ-014 SHALL encode the key code as {row_index[1:0], col_index[1:0]}; physical legend mapping is out of scope.
REQ-015 SHALL evaluate the FSM once per sweep, on the column-3 sample cycle; the FSM has states IDLE, CANDIDATE, PRESSED, RELEASE and a 4-bit agree counter.
REQ-016 In IDLE: key found -> CANDIDATE, cand = code, cnt = 1; none -> stay in IDLE.
REQ-017 In CANDIDATE: same code -> cnt+1; different code -> cand = new code, cnt = 1; none -> IDLE.
REQ-018 SHALL accept the press when cnt reaches DEBOUNCE_SCANS, including cnt = 1 when DEBOUNCE_SCANS = 1; the FSM then enters PRESSED.
REQ-019 On acceptance, keypad_value SHALL take cand and key_valid SHALL pulse and key_held SHALL rise, all on the cycle after the deciding sample cycle.
REQ-020 In PRESSED: any key -> stay, with no further pulses; none -> RELEASE, cnt = 1.
REQ-021 In RELEASE: none -> cnt+1, and at DEBOUNCE_SCANS -> IDLE with key_held falling the next cycle; any key -> PRESSED, with no pulse and keypad_value unchanged.
REQ-022 A different key pressed while in PRESSED SHALL NOT be accepted until a full release is accepted.
REQ-023 key_valid SHALL never be high two consecutive cycles; keypad_value SHALL change only on cycles where key_valid is high.
REQ-024 The dwell counter SHALL wrap from SCAN_DIV-1 to 0 and advance the column on wrap; the column index SHALL wrap from 3 to 0.

Reset
REQ-025 On reset, the block SHALL set col_out = 4'b1110, keypad_value = 4'h0, key_valid = 0, key_held = 0, state = IDLE, cnt = 0, dwell counter = 0, and synchronizer flops = 4'b1111.
REQ-026 Reset asserted mid-press SHALL discard all progress; a held key SHALL be re-accepted only after DEBOUNCE_SCANS fresh sweeps, with a new key_valid pulse.
REQ-027 The first sweep after reset release SHALL begin with column 0.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 2, sweep = 16 cycles)
REQ-028 Reset, rows all high -> col_out = 1110, keypad_value = 0, key_valid = 0, key_held = 0; col_out steps 1101, 1011, 0111 at 4-cycle intervals.
REQ-029 Row 2 low whenever col 1 is driven, held for 5 sweeps -> exactly one key_valid pulse after the 2nd sweep, keypad_value = 4'b1001, key_held = 1 thereafter.
REQ-030 Same key present on alternate sweeps only (bounce) -> no key_valid and keypad_value unchanged.
REQ-031 After REQ-029, release for 1 sweep then re-press -> no new pulse; release for 2 sweeps then re-press -> key_held = 0, then a second pulse with value 9.
REQ-032 Keys row1/col3 and row3/col0 pressed together -> accepted value 4'b1100.
REQ-033 Reset for 1 cycle while key_held = 1 with the key still pressed -> outputs return to reset values, then a fresh pulse 2 sweeps later with the same value.
